pipe_ctrl: RTL and testbench

Pipeline controller for the 5-stage CPU core. It turns busy and hazard inputs into per-stage stall and flush strobes, and owns the control-register file (status, exception vector, EPC, interrupt mask). It also commits exceptions, ERET and WRCR retiring from the MEM stage, and generates the redirect PC for the IF stage. It sits beside the pipeline and drives the `stall`/`flush` inputs of every stage register.

---
 rtl/pipe_ctrl_pkg.sv | 50 +++++
 rtl/pipe_ctrl_creg.sv | 106 ++++++++++
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller:
// creg map, control-op encodings, exception and mode codes.
package pipe_ctrl_pkg;

  typedef enum logic [4:0] {
    CREG_STATUS     = 5'd0,
    CREG_PRE_STATUS = 5'd1,
    CREG_PC         = 5'd2,
    CREG_EXP_VECTOR = 5'd3,
    CREG_CAUSE      = 5'd4,
    CREG_INT_MASK   = 5'd5,
    CREG_IRQ        = 5'd6,
    CREG_EPC        = 5'd7
  } creg_addr_e;

  typedef enum logic [1:0] {
    CTRL_OP_NOP  = 2'd0,
    CTRL_OP_WRCR = 2'd1,
    CTRL_OP_ERET = 2'd2
  } ctrl_op_e;

  localparam logic [2:0] ISA_EXP_NO_EXP = 3'd0;

  localparam logic CPU_KERNEL_MODE = 1'b0;
  localparam logic CPU_USER_MODE   = 1'b1;

  typedef struct packed {
    logic int_en;
    logic exe_mode;
  } status_t;

  typedef struct packed {
    logic       dly;
    logic [2:0] exp_code;
  } cause_t;

  localparam status_t STATUS_RST = '{
    int_en:   1'b0,
    exe_mode: CPU_KERNEL_MODE
  };

  // A faulting branch restarts at the branch itself, one word back.
  function automatic logic [29:0] epc_of(
    input logic [29:0] pc,
    input logic        br
  );
    return br ? pc - 30'd1 : pc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_creg.sv
// Control-register file: STATUS, PRE_STATUS, EXP_VECTOR, CAUSE,
// INT_MASK, IRQ, EPC plus the registered interrupt detect.
module pipe_ctrl_creg
  import pipe_ctrl_pkg::*;
#(
  parameter logic [29:0] EXP_VECTOR_RST = 30'h0,
  parameter int          IRQ_N          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_exp,
  input  logic             i_eret,
  input  logic             i_wrcr,
  input  logic             i_br_flag,
  input  logic [2:0]       i_exp_code,
  input  logic [29:0]      i_mem_pc,
  input  logic [4:0]       i_wr_addr,
  input  logic [31:0]      i_wr_data,
  input  logic [4:0]       i_rd_addr,
  input  logic [29:0]      i_id_pc,
  input  logic [IRQ_N-1:0] i_irq,
  output logic [31:0]      o_rd_data,
  output logic [29:0]      o_exp_vector,
  output logic [29:0]      o_epc,
  output logic             o_exe_mode,
  output logic             o_int_detect
);

  status_t          r_status;
  status_t          r_pre_status;
  logic [29:0]      r_exp_vector;
  cause_t           r_cause;
  logic [IRQ_N-1:0] r_int_mask;
  logic [IRQ_N-1:0] r_irq;
  logic [29:0]      r_epc;
  logic             r_int_detect;

  logic w_wr_en;
  logic w_unused;

  assign w_wr_en  = i_wrcr & (r_status.exe_mode == CPU_KERNEL_MODE);
  assign w_unused = &{1'b0, i_wr_data[31:30]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status     <= STATUS_RST;
      r_pre_status <= '0;
      r_exp_vector <= EXP_VECTOR_RST;
      r_cause      <= '0;
      r_int_mask   <= '1;
      r_irq        <= '0;
      r_epc        <= '0;
      r_int_detect <= 1'b0;
    end else begin
      r_irq        <= i_irq;
      r_int_detect <= r_status.int_en
                    & (|(i_irq & ~r_int_mask));
      if (i_exp) begin
        r_pre_status <= r_status;
        r_status     <= STATUS_RST;
        r_cause      <= '{dly: i_br_flag,
                          exp_code: i_exp_code};
        r_epc        <= epc_of(i_mem_pc, i_br_flag);
      end else if (i_eret) begin
        r_status <= r_pre_status;
      end else if (w_wr_en) begin
        case (i_wr_addr)
          CREG_STATUS:
            r_status <= status_t'(i_wr_data[1:0]);
          CREG_PRE_STATUS:
            r_pre_status <= status_t'(i_wr_data[1:0]);
          CREG_EXP_VECTOR:
            r_exp_vector <= i_wr_data[29:0];
          CREG_CAUSE:
            r_cause <= cause_t'(i_wr_data[3:0]);
          CREG_INT_MASK:
            r_int_mask <= i_wr_data[IRQ_N-1:0];
          CREG_EPC:
            r_epc <= i_wr_data[29:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_addr)
      CREG_STATUS:     o_rd_data[1:0] = r_status;
      CREG_PRE_STATUS: o_rd_data[1:0] = r_pre_status;
      CREG_PC:         o_rd_data[29:0] = i_id_pc;
      CREG_EXP_VECTOR: o_rd_data[29:0] = r_exp_vector;
      CREG_CAUSE:      o_rd_data[3:0] = r_cause;
      CREG_INT_MASK:   o_rd_data[IRQ_N-1:0] = r_int_mask;
      CREG_IRQ:        o_rd_data[IRQ_N-1:0] = r_irq;
      CREG_EPC:        o_rd_data[29:0] = r_epc;
      default:         o_rd_data = '0;
    endcase
  end

  assign o_exp_vector = r_exp_vector;
  assign o_epc        = r_epc;
  assign o_exe_mode   = r_status.exe_mode;
  assign o_int_detect = r_int_detect;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush strobes, boot restart,
// commit of exception/ERET/WRCR and IF redirect PC.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [29:0] RESET_VECTOR   = 30'h0,
  parameter logic [29:0] EXP_VECTOR_RST = 30'h0,
  parameter int          IRQ_N          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_N-1:0] irq,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic             ld_hazard,
  input  logic [29:0]      id_pc,
  input  logic [29:0]      mem_pc,
  input  logic             mem_en,
  input  logic             mem_br_flag,
  input  logic [1:0]       mem_ctrl_op,
  input  logic [4:0]       mem_dst_addr,
  input  logic [31:0]      mem_out,
  input  logic [2:0]       mem_exp_code,
  input  logic [4:0]       creg_rd_addr,
  output logic [31:0]      creg_rd_data,
  output logic             exe_mode,
  output logic             int_detect,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic [29:0]      new_pc
);

  logic        r_boot;
  logic        w_stall;
  logic        w_commit;
  logic        w_exp;
  logic        w_eret;
  logic        w_wrcr;
  logic        w_ld_flush;
  logic [3:0]  w_flush;
  logic [29:0] w_new_pc;
  logic [29:0] w_exp_vector;
  logic [29:0] w_epc;

  assign w_stall  = if_busy | mem_busy;
  assign w_commit = mem_en & ~w_stall & ~r_boot;
  assign w_exp    = w_commit
                  & (mem_exp_code != ISA_EXP_NO_EXP);
  assign w_eret   = w_commit & ~w_exp
                  & (mem_ctrl_op == CTRL_OP_ERET);
  assign w_wrcr   = w_commit & ~w_exp
                  & (mem_ctrl_op == CTRL_OP_WRCR);

  // Kept disjoint from the redirect cases so the decode is one-hot.
  assign w_ld_flush = ld_hazard & ~w_stall & ~r_boot
                    & ~w_exp & ~w_eret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_boot <= 1'b1;
    else        r_boot <= 1'b0;
  end

  always_comb begin
    w_flush  = 4'b0000;
    w_new_pc = '0;
    unique case (1'b1)
      r_boot: begin
        w_flush  = 4'b1111;
        w_new_pc = RESET_VECTOR;
      end
      w_exp: begin
        w_flush  = 4'b1111;
        w_new_pc = w_exp_vector;
      end
      w_eret: begin
        w_flush  = 4'b1111;
        w_new_pc = w_epc;
      end
      w_ld_flush: w_flush = 4'b0100;
      default: ;
    endcase
  end

  assign if_stall  = w_stall | ld_hazard;
  assign id_stall  = w_stall;
  assign ex_stall  = w_stall;
  assign mem_stall = w_stall;

  assign {if_flush, id_flush,
          ex_flush, mem_flush} = w_flush;
  assign new_pc = w_new_pc;

  pipe_ctrl_creg #(
    .EXP_VECTOR_RST(EXP_VECTOR_RST),
    .IRQ_N         (IRQ_N)
  ) u_creg (
    .clk         (clk),
    .rst_n       (reset),
    .i_exp       (w_exp),
    .i_eret      (w_eret),
    .i_wrcr      (w_wrcr),
    .i_br_flag   (mem_br_flag),
    .i_exp_code  (mem_exp_code),
    .i_mem_pc    (mem_pc),
    .i_wr_addr   (mem_dst_addr),
    .i_wr_data   (mem_out),
    .i_rd_addr   (creg_rd_addr),
    .i_id_pc     (id_pc),
    .i_irq       (irq),
    .o_rd_data   (creg_rd_data),
    .o_exp_vector(w_exp_vector),
    .o_epc       (w_epc),
    .o_exe_mode  (exe_mode),
    .o_int_detect(int_detect)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios, then
// random traffic checked against a behavioural model.
module tb_pipe_ctrl;

  localparam logic [29:0] RV  = 30'h100;
  localparam logic [29:0] EVR = 30'h2A0;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        if_busy, mem_busy, ld_hazard;
  logic [29:0] id_pc, mem_pc;
  logic        mem_en, mem_br_flag;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [31:0] mem_out;
  logic [2:0]  mem_exp_code;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode, int_detect;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;

  pipe_ctrl #(
    .RESET_VECTOR  (RV),
    .EXP_VECTOR_RST(EVR),
    .IRQ_N         (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .if_busy     (if_busy),
    .mem_busy    (mem_busy),
    .ld_hazard   (ld_hazard),
    .id_pc       (id_pc),
    .mem_pc      (mem_pc),
    .mem_en      (mem_en),
    .mem_br_flag (mem_br_flag),
    .mem_ctrl_op (mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr),
    .mem_out     (mem_out),
    .mem_exp_code(mem_exp_code),
    .creg_rd_addr(creg_rd_addr),
    .creg_rd_data(creg_rd_data),
    .exe_mode    (exe_mode),
    .int_detect  (int_detect),
    .if_stall    (if_stall),
    .id_stall    (id_stall),
    .ex_stall    (ex_stall),
    .mem_stall   (mem_stall),
    .if_flush    (if_flush),
    .id_flush    (id_flush),
    .ex_flush    (ex_flush),
    .mem_flush   (mem_flush),
    .new_pc      (new_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  fl;
    logic [29:0] pc;
    logic [31:0] rd;
    logic        md;
    logic        idet;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Architectural model state
  logic        m_int_en, m_mode;
  logic [1:0]  m_pre;
  logic [29:0] m_ev, m_epc;
  logic [3:0]  m_cause;
  logic [7:0]  m_mask, m_irq;
  logic        m_idet, m_boot;

  function automatic void model_reset();
    m_int_en = 0; m_mode = 0; m_pre = 0;
    m_ev = EVR; m_epc = 0; m_cause = 0;
    m_mask = 8'hFF; m_irq = 0;
    m_idet = 0; m_boot = 1;
  endfunction

  function automatic logic [31:0] model_read(
    input logic [4:0] a
  );
    case (a)
      5'd0: return {30'd0, m_int_en, m_mode};
      5'd1: return {30'd0, m_pre};
      5'd2: return {2'd0, id_pc};
      5'd3: return {2'd0, m_ev};
      5'd4: return {28'd0, m_cause};
      5'd5: return {24'd0, m_mask};
      5'd6: return {24'd0, m_irq};
      5'd7: return {2'd0, m_epc};
      default: return 32'd0;
    endcase
  endfunction

  // Predict this cycle's outputs, queue them, then advance the
  // model to the state the next clock edge should produce.
  task automatic eval();
    exp_t e;
    logic stall, take, is_exp, is_eret, is_wr, nidet;
    if (!reset) model_reset();
    stall   = if_busy | mem_busy;
    take    = mem_en && !stall && !m_boot;
    is_exp  = take && (mem_exp_code != 0);
    is_eret = take && !is_exp && (mem_ctrl_op == 2);
    is_wr   = take && !is_exp && (mem_ctrl_op == 1);
    e.st = {stall | ld_hazard, stall, stall, stall};
    e.pc = 0;
    if (m_boot) begin
      e.fl = 4'hF; e.pc = RV;
    end else if (is_exp) begin
      e.fl = 4'hF; e.pc = m_ev;
    end else if (is_eret) begin
      e.fl = 4'hF; e.pc = m_epc;
    end else if (ld_hazard && !stall) begin
      e.fl = 4'b0100;
    end else begin
      e.fl = 4'b0000;
    end
    e.rd   = model_read(creg_rd_addr);
    e.md   = m_mode;
    e.idet = m_idet;
    q.push_back(e);
    if (reset) begin
      nidet = m_int_en && ((irq & ~m_mask) != 0);
      if (is_exp) begin
        m_pre   = {m_int_en, m_mode};
        m_int_en = 0;
        m_mode  = 0;
        m_cause = {mem_br_flag, mem_exp_code};
        m_epc   = mem_br_flag ? mem_pc - 1 : mem_pc;
      end else if (is_eret) begin
        {m_int_en, m_mode} = m_pre;
      end else if (is_wr && m_mode == 0) begin
        case (mem_dst_addr)
          5'd0: {m_int_en, m_mode} = mem_out[1:0];
          5'd1: m_pre   = mem_out[1:0];
          5'd3: m_ev    = mem_out[29:0];
          5'd4: m_cause = mem_out[3:0];
          5'd5: m_mask  = mem_out[7:0];
          5'd7: m_epc   = mem_out[29:0];
          default: ;
        endcase
      end
      m_irq  = irq;
      m_idet = nidet;
      m_boot = 0;
    end
  endtask

  task automatic tick();
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1; irq = 0;
    if_busy = 0; mem_busy = 0; ld_hazard = 0;
    id_pc = 30'h1234; mem_pc = 0;
    mem_en = 0; mem_br_flag = 0; mem_ctrl_op = 0;
    mem_dst_addr = 0; mem_out = 0;
    mem_exp_code = 0; creg_rd_addr = 0;
  endtask

  task automatic wrcr(input logic [4:0] a,
                      input logic [31:0] d);
    idle();
    mem_en = 1; mem_ctrl_op = 1;
    mem_dst_addr = a; mem_out = d;
  endtask

  task automatic rd(input logic [4:0] a);
    idle();
    creg_rd_addr = a;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", {28'd0, if_stall, id_stall,
                      ex_stall, mem_stall}, {28'd0, e.st});
        chk("flush", {28'd0, if_flush, id_flush,
                      ex_flush, mem_flush}, {28'd0, e.fl});
        if (e.fl[3])
          chk("new_pc", {2'd0, new_pc}, {2'd0, e.pc});
        chk("creg_rd", creg_rd_data, e.rd);
        chk("exe_mode", {31'd0, exe_mode}, {31'd0, e.md});
        chk("int_det", {31'd0, int_detect},
            {31'd0, e.idet});
      end
    end
  end

  initial begin : driver
    idle();
    reset = 0;
    model_reset();
    @(posedge clk);
    #1;
    tick(); tick();
    idle(); tick();
    idle(); tick();
    idle(); ld_hazard = 1; tick();
    idle(); ld_hazard = 1; mem_busy = 1; tick();
    wrcr(5'd3, 32'h200); tick();
    wrcr(5'd0, 32'h2); tick();
    rd(5'd0); tick();
    idle(); mem_en = 1; mem_exp_code = 3;
    mem_pc = 30'h40; mem_br_flag = 1;
    creg_rd_addr = 5'd3; tick();
    rd(5'd7); tick();
    rd(5'd4); tick();
    rd(5'd0); tick();
    rd(5'd1); tick();
    idle(); mem_en = 1; mem_ctrl_op = 2; tick();
    rd(5'd0); tick();
    wrcr(5'd5, 32'hFE); tick();
    idle(); irq = 8'h01; tick();
    idle(); irq = 8'h01; tick();
    idle(); irq = 8'h02; tick();
    idle(); irq = 8'h02; creg_rd_addr = 6; tick();
    wrcr(5'd0, 32'h3); tick();
    wrcr(5'd5, 32'h0); tick();
    rd(5'd5); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); mem_en = 1; mem_exp_code = 5;
      mem_pc = 30'h77; mem_busy = (i < 2);
      creg_rd_addr = 5'd0; tick();
    end
    rd(5'd7); tick();
    rd(5'd1); tick();
    idle(); mem_en = 1; mem_exp_code = 1;
    mem_pc = 30'h0; mem_br_flag = 1; tick();
    rd(5'd7); tick();
    idle(); reset = 0; creg_rd_addr = 5'd3; tick();
    idle(); mem_en = 1; mem_exp_code = 2;
    creg_rd_addr = 5'd4; tick();
    rd(5'd4); tick();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) != 0);
      irq          = 8'($urandom);
      if_busy      = ($urandom_range(0, 7) == 0);
      mem_busy     = ($urandom_range(0, 7) == 0);
      ld_hazard    = ($urandom_range(0, 5) == 0);
      id_pc        = 30'($urandom);
      mem_pc       = ($urandom_range(0, 9) == 0)
                   ? 30'd0 : 30'($urandom);
      mem_en       = $urandom_range(0, 1) == 1;
      mem_br_flag  = $urandom_range(0, 1) == 1;
      mem_ctrl_op  = 2'($urandom);
      mem_dst_addr = ($urandom_range(0, 9) == 0)
                   ? 5'($urandom) : 5'($urandom_range(0, 7));
      mem_out      = $urandom;
      mem_exp_code = ($urandom_range(0, 4) == 0)
                   ? 3'($urandom_range(1, 7)) : 3'd0;
      creg_rd_addr = ($urandom_range(0, 9) == 0)
                   ? 5'($urandom) : 5'($urandom_range(0, 7));
      tick();
    end
    @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
